// File: rtl/aes_cipher_iter.sv
// Iterative AES round engine: one round per clock, runtime encrypt/decrypt and
// AES-128/192/256 selection, valid/ready handshakes on both sides.
module aes_cipher_iter #(
    parameter int unsigned Nb     = 4,
    parameter int unsigned NR_MAX = 14,
    parameter int unsigned KW     = Nb * (NR_MAX + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  SBox     [0:255],
    input  logic [7:0]  IBox     [0:255],
    input  logic [7:0]  EXP3     [0:255],
    input  logic [7:0]  LN3      [0:255],
    input  logic [31:0] KExp     [0:KW-1],
    input  logic [1:0]  Key_len,
    input  logic        Decrypt,
    input  logic [7:0]  Data_in  [0:4*Nb-1],
    input  logic        In_valid,
    output logic        In_ready,
    output logic [7:0]  Data_out [0:4*Nb-1],
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic        Busy
);

    localparam int unsigned NBYTES = 4 * Nb;
    localparam int unsigned IW     = $clog2(NBYTES);
    localparam int unsigned KIW    = $clog2(KW);
    localparam int unsigned CW     = $clog2(NR_MAX + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         fsm;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  nr;
    logic           dec;
    logic [7:0]     st   [0:NBYTES-1];

    logic           accept;
    logic           last;
    logic [CW-1:0]  kidx;
    logic [7:0]     rkey [0:NBYTES-1];
    logic [7:0]     sb   [0:NBYTES-1];
    logic [7:0]     sr   [0:NBYTES-1];
    logic [7:0]     mc   [0:NBYTES-1];
    logic [7:0]     isr  [0:NBYTES-1];
    logic [7:0]     ark  [0:NBYTES-1];
    logic [7:0]     imc  [0:NBYTES-1];
    logic [7:0]     nxt  [0:NBYTES-1];
    logic [7:0]     ld   [0:NBYTES-1];

    function automatic logic [CW-1:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return CW'(10);
            2'b01:   return CW'(12);
            default: return CW'(14);
        endcase
    endfunction

    // GF(2^8) multiply through log/antilog tables; zero has no logarithm
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        s = {1'b0, LN3[a]} + {1'b0, LN3[b]};
        if (s >= 9'd255) s = s - 9'd255;
        return EXP3[s[7:0]];
    endfunction

    assign In_ready = (fsm == IDLE) || (fsm == DONE && Out_ready);
    assign accept   = In_valid && In_ready;
    assign last     = (cnt == nr);
    assign Data_out = st;

    // Round key: initial whitening key on accept, otherwise the running round's key
    always_comb begin
        if (fsm == RUN) kidx = dec ? CW'(nr - cnt) : cnt;
        else            kidx = Decrypt ? nr_of(Key_len) : '0;
        for (int c = 0; c < int'(Nb); c++) begin
            for (int r = 0; r < 4; r++) begin
                rkey[IW'(4*c + r)] = KExp[KIW'(Nb*kidx + c)][8*(3-r) +: 8];
            end
        end
    end

    // Forward round: SubBytes, ShiftRows, MixColumns
    always_comb begin
        for (int i = 0; i < int'(NBYTES); i++) sb[i] = SBox[st[i]];
        for (int c = 0; c < int'(Nb); c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[IW'(4*c + r)] = sb[IW'(4*((c + r) % 4) + r)];
            end
        end
        for (int c = 0; c < int'(Nb); c++) begin
            for (int r = 0; r < 4; r++) begin
                mc[IW'(4*c + r)] = gmul(sr[IW'(4*c + r)], 8'h02)
                                 ^ gmul(sr[IW'(4*c + (r+1)%4)], 8'h03)
                                 ^ sr[IW'(4*c + (r+2)%4)]
                                 ^ sr[IW'(4*c + (r+3)%4)];
            end
        end
    end

    // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
    always_comb begin
        for (int c = 0; c < int'(Nb); c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[IW'(4*c + r)] = st[IW'(4*((c + 4 - r) % 4) + r)];
            end
        end
        for (int i = 0; i < int'(NBYTES); i++) ark[i] = IBox[isr[i]] ^ rkey[i];
        for (int c = 0; c < int'(Nb); c++) begin
            for (int r = 0; r < 4; r++) begin
                imc[IW'(4*c + r)] = gmul(ark[IW'(4*c + r)], 8'h0e)
                                  ^ gmul(ark[IW'(4*c + (r+1)%4)], 8'h0b)
                                  ^ gmul(ark[IW'(4*c + (r+2)%4)], 8'h0d)
                                  ^ gmul(ark[IW'(4*c + (r+3)%4)], 8'h09);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (dec) nxt[i] = last ? ark[i] : imc[i];
            else     nxt[i] = (last ? sr[i] : mc[i]) ^ rkey[i];
            ld[i] = Data_in[i] ^ rkey[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            Out_valid <= 1'b0;
            Busy      <= 1'b0;
            cnt       <= '0;
            nr        <= '0;
            dec       <= 1'b0;
            for (int i = 0; i < int'(NBYTES); i++) st[i] <= '0;
        end else if (accept) begin
            fsm       <= RUN;
            Busy      <= 1'b1;
            Out_valid <= 1'b0;
            cnt       <= CW'(1);
            nr        <= nr_of(Key_len);
            dec       <= Decrypt;
            st        <= ld;
        end else begin
            case (fsm)
                RUN: begin
                    st  <= nxt;
                    cnt <= CW'(cnt + 1'b1);
                    if (last) begin
                        fsm       <= DONE;
                        Busy      <= 1'b0;
                        Out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        fsm       <= IDLE;
                        Out_valid <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors, latency, backpressure,
// back-to-back accept, parameter latching and mid-block reset.
module tb_aes_cipher_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sbox [0:255];
    logic [7:0]  ibox [0:255];
    logic [7:0]  exp3 [0:255];
    logic [7:0]  ln3  [0:255];
    logic [31:0] kexp [0:59];
    logic [1:0]  key_len;
    logic        decrypt;
    logic [7:0]  din  [0:15];
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  dout [0:15];
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .SBox      (sbox),
        .IBox      (ibox),
        .EXP3      (exp3),
        .LN3       (ln3),
        .KExp      (kexp),
        .Key_len   (key_len),
        .Decrypt   (decrypt),
        .Data_in   (din),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Data_out  (dout),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [127:0] packed_out();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = dout[i];
        return v;
    endfunction

    task automatic set_din(input logic [127:0] v);
        for (int i = 0; i < 16; i++) din[i] = v[127-8*i -: 8];
    endtask

    // Tables derived from the field definition: generator 3, inverse + affine map
    task automatic gen_tables();
        logic [7:0] e, inv, s;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp3[i] = e;
            ln3[e]  = 8'(i);
            e = e ^ xt(e);
        end
        exp3[255] = exp3[0];
        ln3[0]    = 8'h00;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : exp3[(255 - int'(ln3[a])) % 255];
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[a] = s;
            ibox[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Key schedule for key bytes 00,01,02,... of nk words
    task automatic load_key(input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) kexp[i] = 32'h0;
        for (int i = 0; i < nk; i++) kexp[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rc = 8'h01;
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = kexp[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            kexp[i] = kexp[i-nk] ^ t;
        end
    endtask

    // Offer one block, wait for Out_valid; lat = cycle index of Out_valid (accept cycle = 0)
    task automatic run_block(input logic [1:0] kl, input logic dc, input logic [127:0] blk,
                             input bit toggle, input bit b2b,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        key_len   = kl;
        decrypt   = dc;
        set_din(blk);
        in_valid  = 1'b1;
        out_ready = b2b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            if (toggle) begin
                key_len = 2'(key_len + 2'd1);
                decrypt = ~decrypt;
            end
        end while (!out_valid && lat < 40);
        res = packed_out();
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (packed_out() !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", packed_out()); end
        rst = 1'b0;
    endtask

    task automatic test_encrypt();
        logic [127:0] res, exp_ct;
        int lat, nk;
        for (int k = 0; k < 3; k++) begin
            nk     = 4 + 2*k;
            exp_ct = (k == 0) ? CT128 : (k == 1) ? CT192 : CT256;
            load_key(nk);
            run_block(2'(k), 1'b0, PT, 1'b0, 1'b0, res, lat);
            n_checks++;
            if (res !== exp_ct) begin n_fail++; $display("FAIL enc_nk%0d: got %h expected %h", nk, res, exp_ct); end
            n_checks++;
            if (lat != nk + 7) begin n_fail++; $display("FAIL enc_latency_nk%0d: got %0d expected %0d", nk, lat, nk + 7); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL enc_busy_done_nk%0d: got %b expected 0", nk, busy); end
            release_out();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL enc_release_nk%0d: got out_valid=%b in_ready=%b expected 0/1", nk, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_decrypt();
        logic [127:0] res, ct;
        logic [1:0] kl;
        int lat, nk;
        for (int k = 0; k < 3; k++) begin
            nk = 4 + 2*k;
            ct = (k == 0) ? CT128 : (k == 1) ? CT192 : CT256;
            kl = (k == 2) ? 2'b11 : 2'(k);
            load_key(nk);
            run_block(kl, 1'b1, ct, 1'b0, 1'b0, res, lat);
            n_checks++;
            if (res !== PT) begin n_fail++; $display("FAIL dec_nk%0d: got %h expected %h", nk, res, PT); end
            n_checks++;
            if (lat != nk + 7) begin n_fail++; $display("FAIL dec_latency_nk%0d: got %0d expected %0d", nk, lat, nk + 7); end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        int lat;
        load_key(4);
        run_block(2'b00, 1'b0, PT, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== CT128) begin n_fail++; $display("FAIL bp_first: got %h expected %h", res, CT128); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (packed_out() !== CT128 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got data=%h out_valid=%b in_ready=%b expected %h/1/0",
                         i, packed_out(), out_valid, in_ready, CT128);
            end
        end
        run_block(2'b00, 1'b1, CT128, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== PT) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", res, PT); end
        n_checks++;
        if (lat != 11) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 11", lat); end
        release_out();
    endtask

    task automatic test_latching();
        logic [127:0] res;
        int lat;
        load_key(4);
        run_block(2'b00, 1'b0, PT, 1'b1, 1'b0, res, lat);
        key_len = 2'b00;
        decrypt = 1'b0;
        n_checks++;
        if (res !== CT128) begin n_fail++; $display("FAIL latch_data: got %h expected %h", res, CT128); end
        n_checks++;
        if (lat != 11) begin n_fail++; $display("FAIL latch_latency: got %0d expected 11", lat); end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        load_key(4);
        @(negedge clk);
        key_len  = 2'b00;
        decrypt  = 1'b0;
        set_din(PT);
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_checks++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL run_flags: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
                end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_flags: got busy=%b out_valid=%b in_ready=%b expected 0/0/1", busy, out_valid, in_ready);
        end
        n_checks++;
        if (packed_out() !== 128'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", packed_out()); end
        run_block(2'b00, 1'b0, PT, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== CT128) begin n_fail++; $display("FAIL midrst_after: got %h expected %h", res, CT128); end
        n_checks++;
        if (lat != 11) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 11", lat); end
        release_out();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key_len   = 2'b00;
        decrypt   = 1'b0;
        set_din(128'h0);
        gen_tables();
        load_key(4);
        repeat (3) @(posedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_latching();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
